// File: rtl/weighted_blend_pkg.sv
// Shared constants for the CFA green blend: default widths, state encoding
// and the divide-by-255 normalisation constants.
package weighted_blend_pkg;

   localparam int unsigned DEF_PIX_W = 8;
   localparam int unsigned DEF_WT_W  = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_NORM = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int unsigned NORM_RND = 128;
   localparam int unsigned NORM_SH  = 8;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MUL  = ST_MUL,
      NORM = ST_NORM,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/weighted_blend_if.sv
// Start/ready handshake bundle between the weight generator and the blender.
interface weighted_blend_if #(
   parameter int unsigned PIX_W = weighted_blend_pkg::DEF_PIX_W,
   parameter int unsigned WT_W  = weighted_blend_pkg::DEF_WT_W
);
   logic             strat;
   logic [WT_W-1:0]  scaled_hs;
   logic [WT_W-1:0]  scaled_vs;
   logic [PIX_W-1:0] est_h;
   logic [PIX_W-1:0] est_v;
   logic             busy;
   logic             ready;
   logic [PIX_W-1:0] pix_out;
   logic             sat;

   modport master (
      output strat, scaled_hs, scaled_vs, est_h, est_v,
      input  busy, ready, pix_out, sat
   );

   modport slave (
      input  strat, scaled_hs, scaled_vs, est_h, est_v,
      output busy, ready, pix_out, sat
   );
endinterface

// File: rtl/weighted_blend_shift_add_mac.sv
// Two-operand shift-add multiply-accumulate: acc = wt_h*est_v + wt_v*est_h,
// one weight bit per step, operands captured on load.
module shift_add_mac #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned WT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [WT_W-1:0]    wt_h,
   input  logic [WT_W-1:0]    wt_v,
   input  logic [PIX_W-1:0]   est_h,
   input  logic [PIX_W-1:0]   est_v,
   output logic [PIX_W+WT_W:0] acc,
   output logic               last
);
   localparam int unsigned ACC_W = PIX_W + WT_W + 1;
   localparam int unsigned CNT_W = (WT_W > 1) ? $clog2(WT_W) : 1;

   logic [WT_W-1:0]  wt_h_q;
   logic [WT_W-1:0]  wt_v_q;
   logic [PIX_W-1:0] est_h_q;
   logic [PIX_W-1:0] est_v_q;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] term_v;
   logic [ACC_W-1:0] term_h;

   // Partial products for the current weight bit
   always_comb begin
      term_v = '0;
      term_h = '0;
      if (wt_h_q[cnt]) term_v = ACC_W'(est_v_q) << cnt;
      if (wt_v_q[cnt]) term_h = ACC_W'(est_h_q) << cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wt_h_q  <= '0;
         wt_v_q  <= '0;
         est_h_q <= '0;
         est_v_q <= '0;
         cnt     <= '0;
         acc     <= '0;
         last    <= 1'b0;
      end else if (load) begin
         wt_h_q  <= wt_h;
         wt_v_q  <= wt_v;
         est_h_q <= est_h;
         est_v_q <= est_v;
         cnt     <= '0;
         acc     <= '0;
         last    <= 1'(WT_W == 1);
      end else if (step) begin
         acc  <= acc + term_v + term_h;
         cnt  <= cnt + CNT_W'(1);
         // last flags the step that will consume the top weight bit
         last <= (cnt == CNT_W'(WT_W - 2));
      end
   end

endmodule

// File: rtl/weighted_blend.sv
// Directional green blend: weighted sum of est_h/est_v, divided by 255 with
// rounding, clipped to PIX_W bits; one result per start request.
module weighted_blend
   import weighted_blend_pkg::*;
#(
   parameter int unsigned PIX_W = DEF_PIX_W,
   parameter int unsigned WT_W  = DEF_WT_W
) (
   input logic              clk,
   input logic              rst,
   weighted_blend_if.slave  bus
);
   localparam int unsigned ACC_W  = PIX_W + WT_W + 1;
   localparam int unsigned NORM_W = ACC_W + 1;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic [ACC_W-1:0] acc;
   logic             last;

   logic             busy_q,  busy_nxt;
   logic             ready_q, ready_nxt;
   logic [PIX_W-1:0] pix_q,   pix_nxt;
   logic             sat_q,   sat_nxt;
   logic [PIX_W-1:0] res_q,   res_nxt;
   logic             rsat_q,  rsat_nxt;

   logic [NORM_W-1:0] norm_sum_c;
   logic [NORM_W-1:0] norm_c;
   logic              clip_c;

   shift_add_mac #(.PIX_W(PIX_W), .WT_W(WT_W)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .step  (step),
      .wt_h  (bus.scaled_hs),
      .wt_v  (bus.scaled_vs),
      .est_h (bus.est_h),
      .est_v (bus.est_v),
      .acc   (acc),
      .last  (last)
   );

   // acc/255 ~= (acc + acc/256 + 1/2) / 256
   always_comb begin
      norm_sum_c = NORM_W'(acc) + NORM_W'(acc >> NORM_SH) + NORM_W'(NORM_RND);
      norm_c     = norm_sum_c >> NORM_SH;
      clip_c     = norm_c > NORM_W'(2**PIX_W - 1);
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      busy_nxt  = busy_q;
      ready_nxt = 1'b0;
      pix_nxt   = pix_q;
      sat_nxt   = sat_q;
      res_nxt   = res_q;
      rsat_nxt  = rsat_q;
      unique case (state)
         IDLE: begin
            if (bus.strat) begin
               load      = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            step = 1'b1;
            if (last) state_nxt = NORM;
         end
         NORM: begin
            res_nxt   = clip_c ? '1 : norm_c[PIX_W-1:0];
            rsat_nxt  = clip_c;
            state_nxt = DONE;
         end
         DONE: begin
            // Publish result together with the ready pulse
            pix_nxt   = res_q;
            sat_nxt   = rsat_q;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         pix_q   <= '0;
         sat_q   <= 1'b0;
         res_q   <= '0;
         rsat_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         busy_q  <= busy_nxt;
         ready_q <= ready_nxt;
         pix_q   <= pix_nxt;
         sat_q   <= sat_nxt;
         res_q   <= res_nxt;
         rsat_q  <= rsat_nxt;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.ready   = ready_q;
   assign bus.pix_out = pix_q;
   assign bus.sat     = sat_q;

endmodule

// File: tb/tb_weighted_blend.sv
// Directed bench for weighted_blend: latency, blend values, saturation,
// ignored/continuous starts and asynchronous reset mid-operation.
module tb_weighted_blend;

   logic clk;
   logic rst;
   int   passed;
   int   total;

   weighted_blend_if bus ();

   weighted_blend dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic count_ready(input string tag, input int cycles, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready === 1'b1) n++;
      end
      check(tag, 32'(n), 32'(exp));
   endtask

   // Issue one start and check busy/ready every cycle up to the result.
   task automatic run_op(input string tag,
                         input logic [7:0] hs, input logic [7:0] vs,
                         input logic [7:0] eh, input logic [7:0] ev,
                         input int exp_pix, input int exp_sat,
                         input bit keep, input int poke);
      @(negedge clk);
      bus.scaled_hs = hs;
      bus.scaled_vs = vs;
      bus.est_h     = eh;
      bus.est_v     = ev;
      bus.strat     = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) bus.strat = 1'b0;
      bus.scaled_hs = 8'($urandom);
      bus.scaled_vs = 8'($urandom);
      bus.est_h     = 8'($urandom);
      bus.est_v     = 8'($urandom);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (c < 10) begin
            check({tag, "_busy"}, 32'({bus.busy, bus.ready}), 32'd2);
         end else begin
            check({tag, "_ready"}, 32'({bus.busy, bus.ready}), 32'd1);
            check({tag, "_pix"}, 32'(bus.pix_out), 32'(exp_pix));
            check({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
         end
         if (poke != 0 && c == poke) begin
            bus.strat     = 1'b1;
            bus.scaled_hs = 8'd255;
            bus.scaled_vs = 8'd255;
            bus.est_h     = 8'd255;
            bus.est_v     = 8'd255;
         end
         if (poke != 0 && c == poke + 1) bus.strat = 1'b0;
      end
   endtask

   initial begin
      clk           = 1'b0;
      rst           = 1'b0;
      passed        = 0;
      total         = 0;
      bus.strat     = 1'b0;
      bus.scaled_hs = '0;
      bus.scaled_vs = '0;
      bus.est_h     = '0;
      bus.est_v     = '0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_pix", 32'(bus.pix_out), 32'd0);
      check("rst_sat", 32'(bus.sat), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      count_ready("idle_no_ready", 20, 0);
      check("idle_pix", 32'(bus.pix_out), 32'd0);

      // Nominal: 128*200 + 127*100 = 38300 -> 150
      run_op("nominal", 8'd128, 8'd127, 8'd100, 8'd200, 150, 0, 1'b0, 0);
      // 255*255 = 65025 -> 255, no clip
      run_op("ext_hi", 8'd255, 8'd0, 8'd77, 8'd255, 255, 0, 1'b0, 0);
      run_op("ext_lo", 8'd0, 8'd255, 8'd0, 8'd200, 0, 0, 1'b0, 0);
      // 130050 -> 510, clipped
      run_op("satur", 8'd255, 8'd255, 8'd255, 8'd255, 255, 1, 1'b0, 0);
      run_op("zero_wt", 8'd0, 8'd0, 8'd255, 8'd255, 0, 0, 1'b0, 0);

      // Start while busy is dropped: 64*120 + 191*40 = 15320 -> 60
      run_op("ignored", 8'd64, 8'd191, 8'd40, 8'd120, 60, 0, 1'b0, 3);
      count_ready("not_queued", 15, 0);

      // strat held high: results back to back every 11 cycles
      run_op("cont1", 8'd200, 8'd55, 8'd10, 8'd250, 198, 0, 1'b1, 0);
      run_op("cont2", 8'd100, 8'd155, 8'd250, 8'd30, 164, 0, 1'b1, 0);
      bus.strat = 1'b0;
      count_ready("cont_stop", 15, 0);

      // Async reset four cycles into MUL
      @(negedge clk);
      bus.scaled_hs = 8'd255;
      bus.scaled_vs = 8'd255;
      bus.est_h     = 8'd255;
      bus.est_v     = 8'd255;
      bus.strat     = 1'b1;
      @(posedge clk);
      #1;
      bus.strat = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_ready", 32'(bus.ready), 32'd0);
      check("mid_rst_pix", 32'(bus.pix_out), 32'd0);
      check("mid_rst_sat", 32'(bus.sat), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      count_ready("post_rst_quiet", 15, 0);
      // 10*90 + 245*50 = 13150 -> 52
      run_op("fresh", 8'd10, 8'd245, 8'd50, 8'd90, 52, 0, 1'b0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
